// File: rtl/div_unit_if.sv
// Request and writeback bundle for the iterative divider.
// The master side issues requests; the slave side is the divider.
interface div_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            op;
    logic [DATA_WIDTH-1:0] src1;
    logic [DATA_WIDTH-1:0] src2;
    logic [ADDR_WIDTH-1:0] rd;
    logic                  wb_wen;
    logic [ADDR_WIDTH-1:0] wb_waddr;
    logic [DATA_WIDTH-1:0] wb_wdata;
    logic                  busy;

    modport master (
        output in_valid, op, src1, src2, rd,
        input  in_ready, wb_wen, wb_waddr, wb_wdata, busy
    );

    modport slave (
        input  in_valid, op, src1, src2, rd,
        output in_ready, wb_wen, wb_waddr, wb_wdata, busy
    );
endinterface

// File: rtl/div_unit.sv
// RV32M-style divider: one restoring radix-2 step per cycle, with
// divide-by-zero and signed-overflow cases resolved in a single cycle.
module div_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input logic       clk,
    input logic       rst,
    div_unit_if.slave bus
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0]         LAST_STEP = CW'(DATA_WIDTH - 1);
    localparam logic [DATA_WIDTH-1:0] MIN_VAL   = {1'b1, {(DATA_WIDTH-1){1'b0}}};
    localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic                  sel_rem;
    logic [ADDR_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] quo;
    logic [DATA_WIDTH-1:0] rem;
    logic [DATA_WIDTH-1:0] divisor;
    logic                  neg_q;
    logic                  neg_r;
    logic                  wen_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic                  accept;
    logic                  is_signed;
    logic                  s1_neg;
    logic                  s2_neg;
    logic [DATA_WIDTH-1:0] s1_mag;
    logic [DATA_WIDTH-1:0] s2_mag;
    logic                  div_zero;
    logic                  overflow;
    logic [DATA_WIDTH-1:0] spec_q;
    logic [DATA_WIDTH-1:0] spec_r;
    logic [DATA_WIDTH:0]   rem_shift;
    logic [DATA_WIDTH:0]   diff;
    logic [DATA_WIDTH-1:0] q_next;
    logic [DATA_WIDTH-1:0] r_next;
    logic [DATA_WIDTH-1:0] fin_q;
    logic [DATA_WIDTH-1:0] fin_r;

    assign bus.in_ready = (state == IDLE);
    assign bus.busy     = (state != IDLE);
    assign bus.wb_wen   = wen_q;
    assign bus.wb_waddr = waddr_q;
    assign bus.wb_wdata = wdata_q;

    always_comb begin
        accept    = bus.in_valid && (state == IDLE);
        is_signed = ~bus.op[0];
        s1_neg    = is_signed && bus.src1[DATA_WIDTH-1];
        s2_neg    = is_signed && bus.src2[DATA_WIDTH-1];
        s1_mag    = s1_neg ? (~bus.src1 + ONE) : bus.src1;
        s2_mag    = s2_neg ? (~bus.src2 + ONE) : bus.src2;
        div_zero  = (bus.src2 == '0);
        overflow  = is_signed && (bus.src1 == MIN_VAL) && (bus.src2 == '1);
        spec_q    = div_zero ? '1 : MIN_VAL;
        spec_r    = div_zero ? bus.src1 : '0;
    end

    // A trial subtraction that borrows (diff MSB set) means the divisor did not fit.
    always_comb begin
        rem_shift = {rem, quo[DATA_WIDTH-1]};
        diff      = rem_shift - {1'b0, divisor};
        if (diff[DATA_WIDTH]) begin
            r_next = rem_shift[DATA_WIDTH-1:0];
            q_next = {quo[DATA_WIDTH-2:0], 1'b0};
        end else begin
            r_next = diff[DATA_WIDTH-1:0];
            q_next = {quo[DATA_WIDTH-2:0], 1'b1};
        end
        fin_q = neg_q ? (~q_next + ONE) : q_next;
        fin_r = neg_r ? (~r_next + ONE) : r_next;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            count   <= '0;
            sel_rem <= 1'b0;
            rd_q    <= '0;
            quo     <= '0;
            rem     <= '0;
            divisor <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    wen_q   <= 1'b0;
                    waddr_q <= '0;
                    wdata_q <= '0;
                    if (accept) begin
                        sel_rem <= bus.op[1];
                        rd_q    <= bus.rd;
                        if (div_zero || overflow) begin
                            state   <= DONE;
                            quo     <= spec_q;
                            rem     <= spec_r;
                            wen_q   <= (bus.rd != '0);
                            waddr_q <= bus.rd;
                            wdata_q <= bus.op[1] ? spec_r : spec_q;
                        end else begin
                            state   <= CALC;
                            count   <= '0;
                            quo     <= s1_mag;
                            rem     <= '0;
                            divisor <= s2_mag;
                            neg_q   <= s1_neg ^ s2_neg;
                            neg_r   <= s1_neg;
                        end
                    end
                end
                CALC: begin
                    quo   <= q_next;
                    rem   <= r_next;
                    count <= count + 1'b1;
                    if (count == LAST_STEP) begin
                        state   <= DONE;
                        count   <= '0;
                        quo     <= fin_q;
                        rem     <= fin_r;
                        wen_q   <= (rd_q != '0);
                        waddr_q <= rd_q;
                        wdata_q <= sel_rem ? fin_r : fin_q;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    wen_q   <= 1'b0;
                    waddr_q <= '0;
                    wdata_q <= '0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: requests push expected writebacks into a
// queue that a negedge monitor pops whenever wb_wen is seen.
module tb_div_unit;
    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef struct {
        int          cyc;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    exp_t sbq[$];
    bit   checkIdleNext = 1'b0;

    div_unit_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    div_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: every write pulse must match the oldest expectation, then drop next cycle.
    always @(negedge clk) begin
        if (checkIdleNext) begin
            checkIdleNext = 1'b0;
            checkOutput("wen_pulse_end", {31'd0, bus.wb_wen}, 32'd0);
            checkOutput("waddr_cleared", {27'd0, bus.wb_waddr}, 32'd0);
            checkOutput("wdata_cleared", bus.wb_wdata, 32'd0);
        end
        if (bus.wb_wen === 1'b1) begin
            if (sbq.size() == 0) begin
                checkOutput("unexpected_wen", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                checkOutput("wb_cycle", cyc, e.cyc);
                checkOutput("wb_waddr", {27'd0, bus.wb_waddr}, {27'd0, e.addr});
                checkOutput("wb_wdata", bus.wb_wdata, e.data);
                checkIdleNext = 1'b1;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] rd, input logic [31:0] expv, input int lat,
                                 input bit pushExp, output int acceptCyc);
        int waited;
        exp_t e;
        waited = 0;
        acceptCyc = -1;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (bus.in_ready !== 1'b1) begin
            checkOutput("ready_timeout", {31'd0, bus.in_ready}, 32'd1);
            return;
        end
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.src1     = a;
        bus.src2     = b;
        bus.rd       = rd;
        acceptCyc    = cyc;
        if (pushExp) begin
            e.cyc  = acceptCyc + lat;
            e.addr = rd;
            e.data = expv;
            sbq.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.src1     = $urandom;
        bus.src2     = $urandom;
        bus.rd       = 5'($urandom);
        checkOutput("busy_after_accept", {31'd0, bus.busy}, 32'd1);
        checkOutput("ready_after_accept", {31'd0, bus.in_ready}, 32'd0);
    endtask

    initial begin
        int n;
        int m;
        int waited;
        exp_t e;

        bus.in_valid = 1'b0;
        bus.op       = '0;
        bus.src1     = '0;
        bus.src2     = '0;
        bus.rd       = '0;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_wen", {31'd0, bus.wb_wen}, 32'd0);
        checkOutput("reset_wdata", bus.wb_wdata, 32'd0);

        applyStimulus(OP_DIVU, 32'd100,        32'd7,          5'd5,  32'd14,         33, 1'b1, n);
        applyStimulus(OP_REMU, 32'd100,        32'd7,          5'd5,  32'd2,          33, 1'b1, n);
        applyStimulus(OP_DIV,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFD,  33, 1'b1, n);
        applyStimulus(OP_REM,  32'hFFFF_FFF9,  32'd2,          5'd3,  32'hFFFF_FFFF,  33, 1'b1, n);
        applyStimulus(OP_DIV,  32'd7,          32'hFFFF_FFFE,  5'd4,  32'hFFFF_FFFD,  33, 1'b1, n);
        applyStimulus(OP_REM,  32'd7,          32'hFFFF_FFFE,  5'd4,  32'd1,          33, 1'b1, n);
        applyStimulus(OP_DIV,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd6,  32'd3,          33, 1'b1, n);
        applyStimulus(OP_REM,  32'hFFFF_FFF9,  32'hFFFF_FFFE,  5'd6,  32'hFFFF_FFFF,  33, 1'b1, n);
        applyStimulus(OP_REM,  32'hFFFF_FFF8,  32'd2,          5'd8,  32'd0,          33, 1'b1, n);
        applyStimulus(OP_DIVU, 32'hFFFF_FFFF,  32'd1,          5'd9,  32'hFFFF_FFFF,  33, 1'b1, n);
        applyStimulus(OP_REMU, 32'hFFFF_FFFF,  32'h10,         5'd10, 32'hF,          33, 1'b1, n);
        applyStimulus(OP_DIVU, 32'd3,          32'd5,          5'd11, 32'd0,          33, 1'b1, n);
        applyStimulus(OP_DIVU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'd0,          33, 1'b1, n);
        applyStimulus(OP_REMU, 32'h8000_0000,  32'hFFFF_FFFF,  5'd12, 32'h8000_0000,  33, 1'b1, n);
        applyStimulus(OP_DIVU, 32'd5,          32'd0,          5'd1,  32'hFFFF_FFFF,  1,  1'b1, n);
        applyStimulus(OP_REMU, 32'd5,          32'd0,          5'd1,  32'd5,          1,  1'b1, n);
        applyStimulus(OP_DIV,  32'hFFFF_FFFB,  32'd0,          5'd2,  32'hFFFF_FFFF,  1,  1'b1, n);
        applyStimulus(OP_REM,  32'hFFFF_FFFB,  32'd0,          5'd2,  32'hFFFF_FFFB,  1,  1'b1, n);
        applyStimulus(OP_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1,  1'b1, n);
        applyStimulus(OP_REM,  32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'd0,          1,  1'b1, n);

        // Reset mid-operation: the pending DIVU must never write back.
        applyStimulus(OP_DIVU, 32'd100, 32'd7, 5'd7, 32'd14, 33, 1'b0, n);
        waited = 0;
        while (cyc < n + 10 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        checkOutput("post_rst_busy", {31'd0, bus.busy}, 32'd0);
        repeat (40) @(negedge clk);

        // rd=0 with in_valid held: second request waits for the full latency.
        applyStimulus(OP_DIVU, 32'd9, 32'd3, 5'd0, 32'd3, 33, 1'b0, n);
        bus.in_valid = 1'b1;
        bus.op       = OP_DIVU;
        bus.src1     = 32'd20;
        bus.src2     = 32'd4;
        bus.rd       = 5'd7;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        m = cyc;
        checkOutput("second_accept_cycle", m, n + 34);
        e.cyc  = m + 33;
        e.addr = 5'd7;
        e.data = 32'd5;
        sbq.push_back(e);
        @(negedge clk);
        bus.in_valid = 1'b0;

        waited = 0;
        while (sbq.size() != 0 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        while (sbq.size() != 0) begin
            e = sbq.pop_front();
            checkOutput("missing_wb", 32'd0, e.data);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (iteration count equals DATA_WIDTH).
REQ-002 SHALL have parameter ADDR_WIDTH, default 5, destination register index width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  request present on src1/src2/op/rd.
REQ-006 SHALL have port in_ready  output  1  unit accepts a request this cycle.
REQ-007 SHALL have port op  input  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (RV32M encoding order).
REQ-008 SHALL have port src1  input  DATA_WIDTH  dividend, taken from register-file read data.
REQ-009 SHALL have port src2  input  DATA_WIDTH  divisor, taken from register-file read data.
REQ-010 SHALL have port rd  input  ADDR_WIDTH  destination register index.
REQ-011 SHALL have port wb_wen  output  1  register-file write enable, one-cycle pulse.
REQ-012 SHALL have port wb_waddr  output  ADDR_WIDTH  register-file write address.
REQ-013 SHALL have port wb_wdata  output  DATA_WIDTH  register-file write data.
REQ-014 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = (state == IDLE), combinational.
REQ-016 SHALL accept a request only in a cycle with in_valid && in_ready, latching op, rd, operands.
REQ-017 SHALL ignore in_valid while busy; no queuing, latched operands unchanged.
REQ-018 SHALL, for a normal accept in cycle N, go IDLE->CALC, spend cycles N+1..N+32 in CALC (one restoring radix-2 iteration per cycle, counter 0..DATA_WIDTH-1), enter DONE in cycle N+33.
REQ-019 SHALL treat divisor == 0 as special: go IDLE->DONE directly (DONE in cycle N+1); quotient = all ones, remainder = src1 (signed and unsigned).
REQ-020 SHALL treat DIV/REM with src1 == 0x80000000 and src2 == 0xFFFFFFFF as special: DONE in cycle N+1; quotient = 0x80000000, remainder = 0.
REQ-021 SHALL, for signed ops, divide magnitudes; quotient negated when operand signs differ; remainder takes the sign of the dividend; remainder 0 never negated.
REQ-022 SHALL maintain the invariant src1 == quotient*src2 + remainder modulo 2^DATA_WIDTH for all non-zero divisors.
REQ-023 SHALL drive wb_wen = 1 for exactly the single DONE cycle, with wb_waddr = latched rd, wb_wdata = quotient (DIV/DIVU) or remainder (REM/REMU).
REQ-024 SHALL hold wb_wen = 0 in DONE when latched rd == 0, still consuming full latency.
REQ-025 SHALL drive wb_wen, wb_waddr, wb_wdata from registers (no combinational path from inputs).
REQ-026 SHALL transition DONE->IDLE unconditionally on the next edge; new accept possible in cycle N+34 (normal) or N+2 (special).
REQ-027 SHALL hold wb_waddr and wb_wdata at 0 outside DONE.

Reset
REQ-028 SHALL, when rst is high at a rising edge, force state IDLE, counter 0, wb_wen 0, wb_waddr 0, wb_wdata 0, internal quotient/remainder 0.
REQ-029 SHALL give rst priority over any accept or iteration in the same cycle; an in-flight operation is discarded with no writeback.
REQ-030 SHALL present in_ready = 1, busy = 0 in the first cycle after reset deasserts.

Verification
REQ-031 SHALL pass: DIVU 100/7 rd=5 accepted cycle N -> cycle N+33 wb_wen=1, wb_waddr=5, wb_wdata=14; REMU same operands -> wb_wdata=2.
REQ-032 SHALL pass: DIV 0xFFFFFFF9/2 rd=3 -> N+33 wb_wdata=0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE -> 0xFFFFFFFD.
REQ-033 SHALL pass: DIVU 5/0 rd=1 -> cycle N+1 wb_wen=1, wb_wdata=0xFFFFFFFF; REMU 5/0 -> 5; DIV 0xFFFFFFFB/0 -> 0xFFFFFFFF.
REQ-034 SHALL pass: DIV 0x80000000/0xFFFFFFFF -> cycle N+1 wb_wdata=0x80000000; REM same -> 0.
REQ-035 SHALL pass: rst pulsed in cycle N+10 of a DIVU -> wb_wen stays 0 for 40 cycles, in_ready=1 and busy=0 from next cycle.
REQ-036 SHALL pass: DIVU 9/3 rd=0 with in_valid held high during CALC (different operands) -> wb_wen never asserted, second request accepted only in cycle N+34.
